// File: rtl/definitions.sv
// Shared pipeline types for the memory stage: control/data bundles and FSM states.
package definitions;

   typedef logic [4:0]  RegAddr;
   typedef logic [31:0] Word;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
   } M_ctrl;

   typedef struct packed {
      RegAddr dst;
      Word    addr;
      Word    val;
      logic   alu_zero;
      Word    pc_branch;
   } M_data;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } MW_ctrl;

   typedef enum logic [1:0] {IDLE, REQ, DONE} MemState;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access.sv
// Memory-stage access engine: runs loads/stores on the dmem bus and stalls the pipe.
// Define MEM_TIMEOUT_EN to abort a request after TIMEOUT cycles without ack.
module mem_access
   import definitions::*;
#(
   parameter int unsigned TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic   clk,
   input  logic   rst,
   input  M_ctrl  m_ctrl,
   input  M_data  m_data,
   input  MW_ctrl mw_ctrl,
   output logic   dmem_req,
   output logic   dmem_we,
   output Word    dmem_addr,
   output Word    dmem_wdata,
   input  Word    dmem_rdata,
   input  logic   dmem_ack,
   output logic   mem_stall,
   output logic   w_valid,
   output RegAddr w_dst,
   output Word    w_val,
   output MW_ctrl w_ctrl,
   output logic   mem_fault
);

   MemState state_q, state_d;
   Word     addr_q, addr_d;
   Word     wdata_q, wdata_d;
   Word     rdata_q, rdata_d;
   RegAddr  dst_q, dst_d;
   MW_ctrl  ctrl_q, ctrl_d;
   logic    we_q, we_d;
   logic    to_q, to_d;
   logic    w_valid_q, w_valid_d;
   RegAddr  w_dst_q, w_dst_d;
   Word     w_val_q, w_val_d;
   MW_ctrl  w_ctrl_q, w_ctrl_d;
   logic    fault_q, fault_d;
   logic    is_mem;
   logic    timeout_hit;
   logic    unused_bits;

   assign is_mem = m_ctrl.mem_read | m_ctrl.mem_write;
   assign unused_bits = ^{m_data.alu_zero, m_data.pc_branch};

`ifdef MEM_TIMEOUT_EN
   localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   logic [CW-1:0] cnt_q, cnt_d;

   // Held at zero outside REQ so it starts clean on every entry.
   always_comb begin
      cnt_d = '0;
      if (state_q == REQ && !dmem_ack) cnt_d = cnt_q + 1'b1;
   end

   assign timeout_hit = (state_q == REQ) && (cnt_d == CW'(TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   localparam bit unused_timeout = (TIMEOUT != 0);

   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      dst_d      = dst_q;
      ctrl_d     = ctrl_q;
      we_d       = we_q;
      to_d       = to_q;
      w_valid_d  = 1'b0;
      w_dst_d    = w_dst_q;
      w_val_d    = w_val_q;
      w_ctrl_d   = w_ctrl_q;
      fault_d    = 1'b0;
      mem_stall  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = we_q;
      dmem_addr  = addr_q;
      dmem_wdata = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (is_mem) begin
               mem_stall = 1'b1;
               addr_d    = m_data.addr;
               wdata_d   = m_data.val;
               dst_d     = m_data.dst;
               ctrl_d    = mw_ctrl;
               we_d      = m_ctrl.mem_write;
               to_d      = 1'b0;
               state_d   = REQ;
            end else begin
               w_valid_d = |mw_ctrl;
               w_dst_d   = m_data.dst;
               w_val_d   = m_data.addr;
               w_ctrl_d  = mw_ctrl;
            end
         end
         REQ: begin
            dmem_req  = 1'b1;
            mem_stall = 1'b1;
            // Ack beats a coinciding timeout; stores retire with zero.
            if (dmem_ack) begin
               rdata_d = we_q ? '0 : dmem_rdata;
               state_d = DONE;
            end else if (timeout_hit) begin
               rdata_d = '0;
               to_d    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            w_valid_d = 1'b1;
            w_dst_d   = dst_q;
            w_val_d   = rdata_q;
            w_ctrl_d  = ctrl_q;
            fault_d   = to_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         dst_q     <= '0;
         ctrl_q    <= '0;
         we_q      <= 1'b0;
         to_q      <= 1'b0;
         w_valid_q <= 1'b0;
         w_dst_q   <= '0;
         w_val_q   <= '0;
         w_ctrl_q  <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         dst_q     <= dst_d;
         ctrl_q    <= ctrl_d;
         we_q      <= we_d;
         to_q      <= to_d;
         w_valid_q <= w_valid_d;
         w_dst_q   <= w_dst_d;
         w_val_q   <= w_val_d;
         w_ctrl_q  <= w_ctrl_d;
         fault_q   <= fault_d;
      end
   end

   assign w_valid   = w_valid_q;
   assign w_dst     = w_dst_q;
   assign w_val     = w_val_q;
   assign w_ctrl    = w_ctrl_q;
   assign mem_fault = fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level timing model.
module tb_mem_access;
   import definitions::*;

`ifdef MEM_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic   clk = 1'b0;
   logic   rst;
   M_ctrl  m_ctrl;
   M_data  m_data;
   MW_ctrl mw_ctrl;
   logic   dmem_req, dmem_we, dmem_ack;
   Word    dmem_addr, dmem_wdata, dmem_rdata;
   logic   mem_stall, w_valid, mem_fault;
   RegAddr w_dst;
   Word    w_val;
   MW_ctrl w_ctrl;

   mem_access #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m_ctrl(m_ctrl), .m_data(m_data), .mw_ctrl(mw_ctrl),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .mem_stall(mem_stall), .w_valid(w_valid), .w_dst(w_dst),
      .w_val(w_val), .w_ctrl(w_ctrl), .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int stall_n, req_n, wv_n;

   // Expected outputs for the current cycle, and registered values due next edge.
   logic   exp_stall, exp_req, exp_we, exp_wv, exp_fault;
   Word    exp_addr, exp_wdata, exp_val;
   RegAddr exp_dst;
   MW_ctrl exp_ctrl;
   logic   nxt_ret, nxt_wv, nxt_fault;
   Word    nxt_val;
   RegAddr nxt_dst;
   MW_ctrl nxt_ctrl;

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("mem_stall", 32'(mem_stall), 32'(exp_stall));
      chk("dmem_req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
         chk("dmem_we", 32'(dmem_we), 32'(exp_we));
         chk("dmem_addr", dmem_addr, exp_addr);
         chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
      chk("w_valid", 32'(w_valid), 32'(exp_wv));
      chk("w_dst", 32'(w_dst), 32'(exp_dst));
      chk("w_val", w_val, exp_val);
      chk("w_ctrl", 32'(w_ctrl), 32'(exp_ctrl));
      chk("mem_fault", 32'(mem_fault), 32'(exp_fault));
      stall_n += int'(mem_stall);
      req_n   += int'(dmem_req);
      wv_n    += int'(w_valid);
   end

   function automatic M_data rand_data();
      M_data d;
      d.dst       = RegAddr'($urandom);
      d.addr      = $urandom;
      d.val       = $urandom;
      d.alu_zero  = 1'($urandom);
      d.pc_branch = $urandom;
      return d;
   endfunction

   task automatic model_reset();
      exp_stall = 0; exp_req = 0; exp_we = 0; exp_wv = 0; exp_fault = 0;
      exp_addr = 0; exp_wdata = 0; exp_val = 0; exp_dst = 0; exp_ctrl = 0;
      nxt_ret = 0; nxt_wv = 0; nxt_fault = 0;
      nxt_val = 0; nxt_dst = 0; nxt_ctrl = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      exp_wv    = nxt_wv;
      exp_fault = nxt_fault;
      if (nxt_ret) begin
         exp_dst  = nxt_dst;
         exp_val  = nxt_val;
         exp_ctrl = nxt_ctrl;
      end
      nxt_ret = 0; nxt_wv = 0; nxt_fault = 0;
      exp_req = 0; exp_stall = 0;
      dmem_ack = 0;
   endtask

   task automatic idle(input logic ack);
      tick();
      m_ctrl = '0; m_data = '0; mw_ctrl = '0;
      dmem_ack = ack; dmem_rdata = $urandom;
      nxt_ret = 1; nxt_wv = 0;
      nxt_dst = 0; nxt_val = 0; nxt_ctrl = 0;
   endtask

   task automatic nonmem(input RegAddr d, input Word a, input MW_ctrl c);
      tick();
      m_ctrl = '0;
      m_data = rand_data();
      m_data.dst = d;
      m_data.addr = a;
      mw_ctrl = c;
      dmem_ack = ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
      nxt_ret = 1; nxt_wv = (c != 0);
      nxt_dst = d; nxt_val = a; nxt_ctrl = c;
   endtask

   task automatic memop(input logic rd, input logic wr, input Word a,
                        input Word v, input RegAddr d, input MW_ctrl c,
                        input int waits, input Word rdat);
      logic fault;
      int   n;
      tick();
      m_ctrl = '{mem_read: rd, mem_write: wr};
      m_data = rand_data();
      m_data.dst = d; m_data.addr = a; m_data.val = v;
      mw_ctrl = c;
      exp_stall = 1;
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      fault = 0;
      n = waits;
      if (waits >= TO) begin
         fault = 1;
         n = TO - 1;
      end
      for (int i = 0; i <= n; i++) begin
         tick();
         m_data = rand_data();
         exp_req = 1; exp_stall = 1;
         exp_we = wr; exp_addr = a; exp_wdata = v;
         dmem_ack = (i == n) && !fault;
         dmem_rdata = dmem_ack ? rdat : $urandom;
      end
      tick();
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      nxt_ret = 1; nxt_wv = 1;
      nxt_dst = d; nxt_ctrl = c; nxt_fault = fault;
      nxt_val = (fault || wr) ? 32'h0 : rdat;
   endtask

   initial begin
      rst = 0;
      m_ctrl = '0; m_data = '0; mw_ctrl = '0;
      dmem_ack = 0; dmem_rdata = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1;

      // Non-memory op retires next cycle.
      stall_n = 0;
      nonmem(5'd5, 32'h10, '{reg_write: 1'b1, mem_to_reg: 1'b0});
      idle(0);
      chk("np_valid", 32'(w_valid), 32'd1);
      chk("np_dst", 32'(w_dst), 32'd5);
      chk("np_val", w_val, 32'h10);
      idle(0);
      chk("np_stall_cnt", 32'(stall_n), 32'd0);

      // Load, ack on first REQ cycle.
      stall_n = 0; req_n = 0;
      memop(1, 0, 32'h100, 32'h0, 5'd7, '{reg_write: 1'b1, mem_to_reg: 1'b1}, 0, 32'hCAFEF00D);
      idle(0);
      chk("ld_val", w_val, 32'hCAFEF00D);
      chk("ld_dst", 32'(w_dst), 32'd7);
      chk("ld_valid", 32'(w_valid), 32'd1);
      idle(0);
      chk("ld_req_cnt", 32'(req_n), 32'd1);
      chk("ld_stall_cnt", 32'(stall_n), 32'd2);

      // Store with three wait cycles.
      req_n = 0; wv_n = 0;
      memop(0, 1, 32'h200, 32'h1234, 5'd3, '{reg_write: 1'b0, mem_to_reg: 1'b0}, 3, 32'hDEAD);
      idle(0);
      chk("st_val", w_val, 32'h0);
      chk("st_valid", 32'(w_valid), 32'd1);
      idle(0);
      chk("st_req_cnt", 32'(req_n), 32'd4);
      chk("st_wv_cnt", 32'(wv_n), 32'd1);

      // Reset in the middle of REQ.
      tick();
      m_ctrl = '{mem_read: 1'b1, mem_write: 1'b0};
      m_data = rand_data();
      mw_ctrl = '{reg_write: 1'b1, mem_to_reg: 1'b1};
      exp_stall = 1;
      tick();
      exp_req = 1; exp_stall = 1; exp_we = 0;
      exp_addr = m_data.addr; exp_wdata = m_data.val;
      #2;
      rst = 0;
      m_ctrl = '0; m_data = '0; mw_ctrl = '0;
      model_reset();
      #1;
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_stall", 32'(mem_stall), 32'd0);
      tick();
      rst = 1;
      wv_n = 0;
      repeat (3) idle(1);
      idle(0);
      chk("rst_no_wv", 32'(wv_n), 32'd0);

`ifdef MEM_TIMEOUT_EN
      memop(1, 0, 32'h300, 32'h0, 5'd9, '{reg_write: 1'b1, mem_to_reg: 1'b1}, 50, 32'h0);
      idle(0);
      chk("to_fault", 32'(mem_fault), 32'd1);
      chk("to_valid", 32'(w_valid), 32'd1);
      chk("to_val", w_val, 32'h0);
      memop(1, 0, 32'h304, 32'h0, 5'd10, '{reg_write: 1'b1, mem_to_reg: 1'b1}, TO - 1, 32'h5A5A_0001);
      idle(0);
      chk("race_fault", 32'(mem_fault), 32'd0);
      chk("race_val", w_val, 32'h5A5A_0001);
`endif

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            nonmem(RegAddr'($urandom), $urandom, MW_ctrl'(2'($urandom)));
         end else begin
            logic rd, wr;
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            memop(rd, wr, $urandom, $urandom, RegAddr'($urandom),
                  MW_ctrl'(2'($urandom)), $urandom_range(0, 6), $urandom);
         end
      end
      idle(0);
      idle(0);
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-stage access engine that consumes the execute/memory pipeline register outputs (`m_ctrl`, `m_data`, `mw_ctrl`) and drives the data-memory request/acknowledge bus. For loads and stores it runs a multi-cycle state machine and holds the pipeline with `mem_stall`, which the hazard unit turns into upstream stalls. It produces the registered result presented to the memory/writeback register. Non-memory instructions pass through with one cycle of latency.

## Interface
- `TIMEOUT`, default 255: REQ-state cycles without `dmem_ack` before abort; only used with `MEM_TIMEOUT_EN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_ctrl`  in  M_ctrl  memory control; uses fields `mem_read` and `mem_write`.
- `m_data`  in  M_data  fields `dst`, `addr` (32), `val` (32), `alu_zero`, `pc_branch`.
- `mw_ctrl`  in  MW_ctrl  writeback control, carried alongside the instruction.
- `dmem_req`  out  1  request valid.
- `dmem_we`  out  1  1 = store, 0 = load.
- `dmem_addr`  out  32  request address.
- `dmem_wdata`  out  32  store data.
- `dmem_rdata`  in  32  load data; valid in the cycle `dmem_ack` = 1.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `mem_stall`  out  1  to the hazard unit: hold the upstream stages.
- `w_valid`  out  1  one-cycle pulse per retired instruction.
- `w_dst`  out  RegAddr  destination register.
- `w_val`  out  32  load data, or the ALU result (`m_data.addr`).
- `w_ctrl`  out  MW_ctrl  registered copy of `mw_ctrl`.
- `mem_fault`  out  1  one-cycle pulse when a timeout abort occurs.

## Operation
- States: IDLE, REQ, DONE.
- **IDLE, no memory op** (`mem_read` = `mem_write` = 0):
  - Register `w_*` from the inputs and set `w_valid` = 1.
  - An all-zero `mw_ctrl` (bubble) still retires, but with `w_valid` = 0.
- **IDLE, memory op:**
  - Assert `mem_stall` combinationally.
  - Capture `addr`, `val`, `dst`, `mw_ctrl`, and `we` = `mem_write` into internal registers.
  - Move to REQ. `w_valid` = 0 this edge.
  - If both `mem_read` and `mem_write` are set, treat the op as a store.
- **REQ:**
  - `dmem_req` = 1; `dmem_we`, `dmem_addr`, `dmem_wdata` come from the captured registers.
  - `mem_stall` = 1.
  - On `dmem_ack`, capture `dmem_rdata` (loads only) and move to DONE.
- **DONE:**
  - `mem_stall` = 0; `dmem_req` = 0.
  - The input at this point still shows the completed instruction and is ignored; it is not reissued.
  - At the edge, register `w_*` from the captured values: `w_val` = load data for loads, 0 for stores. Set `w_valid` = 1 and return to IDLE.
- `dmem_ack` is ignored in IDLE and DONE.
- All outputs except `mem_stall` and the `dmem_*` outputs are registered.

## Timing
- On reset: state = IDLE, and every output is 0 (including `dmem_req`, `mem_stall`, `w_*`, `mem_fault`).
- Reset asserted mid-REQ drops `dmem_req` immediately and abandons the access; the outstanding ack is ignored after reset.
- Non-memory op: `w_*` updated at the edge that ends the cycle it was presented.
- Memory op with ack in the first REQ cycle, presented in cycle 0:
  - `mem_stall` = 1 in cycles 0–1.
  - `dmem_req` = 1 in cycle 1.
  - DONE in cycle 2; `w_valid` = 1 in cycle 3.
- Each wait cycle adds one cycle to this sequence.
- Throughput: one non-memory op per cycle; back-to-back memory ops have a minimum spacing of 3 cycles.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the count reaches `TIMEOUT`, go to DONE with `w_val` = 0 and `mem_fault` pulsed for one cycle, aligned with `w_valid`.
  - Ack and timeout in the same cycle: ack wins, no fault.
- `MEM_TIMEOUT_EN` undefined: REQ waits indefinitely; `mem_fault` is tied to 0 and the counter is absent.

## Structure
- The `definitions` package gains:
  - `MemState` enum {IDLE, REQ, DONE}.
  - `Word` (32-bit) typedef, if not already present.
  - `MEM_TIMEOUT_DEFAULT` = 255.
- `M_ctrl`, `M_data`, `MW_ctrl`, and `RegAddr` are reused from the package unchanged.
- Single module; no sub-module. The timeout counter is an inline `ifdef` block.

## Test plan
- Non-memory op with `addr` = 0x0000_0010, `dst` = 5 → next cycle `w_valid` = 1, `w_dst` = 5, `w_val` = 0x10, `mem_stall` never set.
- Load from `addr` 0x100, ack with rdata 0xCAFE_F00D on the first REQ cycle → `dmem_req` = 1 for exactly 1 cycle, `mem_stall` = 1 for 2 cycles, then `w_val` = 0xCAFE_F00D, `w_dst` correct.
- Store of `val` 0x1234 to 0x200 with ack after 3 wait cycles → `dmem_we` = 1 and `dmem_wdata` = 0x1234 held steady for all 4 REQ cycles; `w_valid` pulses once with `w_val` = 0.
- `rst` driven low during REQ → `dmem_req` and `mem_stall` go to 0 in the same cycle; a later stray ack produces no `w_valid`.
- With `MEM_TIMEOUT_EN` and `TIMEOUT` = 4, no ack → after 4 REQ cycles `mem_fault` = 1 and `w_valid` = 1, with `w_val` = 0.
- With `MEM_TIMEOUT_EN`, ack arriving in the same cycle the count reaches `TIMEOUT` → normal completion with rdata, `mem_fault` = 0.
